sequence_checker: RTL

//  Receive-side monitor for the 0,2,5,8,11,14,0,... 4-bit counting sequence. Samples a

---
 rtl/seq_pkg.sv | 44 ++++
 rtl/seq_succ_lut.sv | 23 ++
 rtl/sequence_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
//   Shared definitions for the 0,2,5,8,11,14 counting sequence: the sequence
//   values, the checker state encoding and a successor lookup function. Used
//   by both the generator and the receive-side checker.
//   No ports (package).
package seq_pkg;

    localparam int SEQ_LEN = 6;

    localparam logic [3:0] SEQ_V0 = 4'd0;
    localparam logic [3:0] SEQ_V1 = 4'd2;
    localparam logic [3:0] SEQ_V2 = 4'd5;
    localparam logic [3:0] SEQ_V3 = 4'd8;
    localparam logic [3:0] SEQ_V4 = 4'd11;
    localparam logic [3:0] SEQ_V5 = 4'd14;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] next;
    } succ_t;

    // Values outside the sequence have no successor; legal=0 and next=0.
    function automatic succ_t seq_succ(input logic [3:0] value);
        succ_t r;
        r.legal = 1'b1;
        r.next  = 4'd0;
        case (value)
            SEQ_V0:  r.next = SEQ_V1;
            SEQ_V1:  r.next = SEQ_V2;
            SEQ_V2:  r.next = SEQ_V3;
            SEQ_V3:  r.next = SEQ_V4;
            SEQ_V4:  r.next = SEQ_V5;
            SEQ_V5:  r.next = SEQ_V0;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_succ_lut.sv
// seq_succ_lut
//   Combinational successor lookup for the counting sequence.
//   Ports:
//     value  in   4  current sequence value
//     legal  out  1  1 = value belongs to the sequence
//     next   out  4  expected next value (0 when not legal)
module seq_succ_lut
    import seq_pkg::*;
(
    input  logic [3:0] value,
    output logic       legal,
    output logic [3:0] next
);

    succ_t succ;

    always_comb begin
        succ  = seq_succ(value);
        legal = succ.legal;
        next  = succ.next;
    end

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker
//   Receive-side monitor for the 0,2,5,8,11,14 counting sequence. Locks after
//   LOCK_CNT consecutive legal transitions, then flags and counts every broken
//   transition; UNLOCK_CNT consecutive breaks drop it back to hunting.
//   Ports:
//     clk         in   1      clock, rising edge
//     reset       in   1      asynchronous, active-high
//     in_valid    in   1      in_data qualifier
//     in_data     in   4      received sequence value
//     clear       in   1      synchronous clear of err_count
//     locked      out  1      1 = LOCKED
//     err_pulse   out  1      accepted sample broke the sequence while LOCKED
//     wrap_pulse  out  1      accepted 14->0 transition while LOCKED
//     err_count   out  ERR_W  saturating error count
//
//   state  | meaning
//   HUNT   | searching for LOCK_CNT consecutive legal transitions, errors ignored
//   LOCKED | tracking the stream, errors flagged and counted
module sequence_checker
    import seq_pkg::*;
#(
    parameter int ERR_W      = 8,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_pulse_d, wrap_pulse_d;
    logic             err_inc;

    logic             prev_legal;
    logic [3:0]       prev_next;
    logic             match;

    seq_succ_lut u_succ (
        .value (prev_q),
        .legal (prev_legal),
        .next  (prev_next)
    );

    assign match = prev_vld_q && prev_legal && (in_data == prev_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            prev_q     <= 4'd0;
            prev_vld_q <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
            err_q      <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            err_pulse  <= err_pulse_d;
            wrap_pulse <= wrap_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        good_d       = good_q;
        bad_d        = bad_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        err_inc      = 1'b0;

        if (in_valid) begin
            // Always follow the stream, even on an error, so a single bad
            // sample costs one error rather than two.
            prev_d     = in_data;
            prev_vld_d = 1'b1;

            // The very first sample has no predecessor to judge against.
            if (prev_vld_q) begin
                case (state_q)
                    HUNT: begin
                        if (match) begin
                            if (good_q == GOOD_LAST) begin
                                state_d = LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            bad_d        = '0;
                            wrap_pulse_d = (prev_q == SEQ_V5) && (in_data == SEQ_V0);
                        end else begin
                            err_pulse_d = 1'b1;
                            err_inc     = 1'b1;
                            if (bad_q == BAD_LAST) begin
                                state_d = HUNT;
                                bad_d   = '0;
                                good_d  = '0;
                            end else begin
                                bad_d = bad_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        if (clear)
            err_d = '0;
        else if (err_inc && (err_q != {ERR_W{1'b1}}))
            err_d = err_q + 1'b1;
        else
            err_d = err_q;
    end

    assign locked    = (state_q == LOCKED);
    assign err_count = err_q;

endmodule
